// File: rtl/matmul_ctrl.sv
//==============================================================================
// Module      : matmul_ctrl
// Description : Sequencer and multiply-accumulate datapath for Z = X * Y on
//               square MATRIX_DIM x MATRIX_DIM matrices held in BRAMs with
//               one-cycle read latency. Each Z element takes N+2 cycles:
//               N ACCUM (issue reads), 1 DRAIN (last product), 1 WRITE.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module matmul_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MATRIX_DIM = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] x_rd_addr,
    input  logic [DATA_WIDTH-1:0] x_dout,
    output logic [ADDR_WIDTH-1:0] y_rd_addr,
    input  logic [DATA_WIDTH-1:0] y_dout,
    output logic [ADDR_WIDTH-1:0] z_wr_addr,
    output logic                  z_wr_en,
    output logic [DATA_WIDTH-1:0] z_din
);

    // Counter width: enough bits to hold 0..MATRIX_DIM-1.
    localparam int                  c_CW   = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
    localparam logic [c_CW-1:0]       c_LAST = c_CW'(MATRIX_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_DIM  = ADDR_WIDTH'(MATRIX_DIM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_i;
    logic [c_CW-1:0]       r_j;
    logic [c_CW-1:0]       r_k;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_x_addr;
    logic [ADDR_WIDTH-1:0] r_y_addr;
    logic [ADDR_WIDTH-1:0] r_z_addr;
    logic                  r_z_we;
    logic [DATA_WIDTH-1:0] r_z_din;

    logic [DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_acc_sum;
    logic [c_CW-1:0]       w_k_next;
    logic [c_CW-1:0]       w_j_next;
    logic [c_CW-1:0]       w_i_next;
    logic                  w_last_elem;

    // Row-major linear address row*N + col.
    function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [c_CW-1:0] row,
                                                     input logic [c_CW-1:0] col);
        return ADDR_WIDTH'(row) * c_DIM + ADDR_WIDTH'(col);
    endfunction

    // Only the low DATA_WIDTH bits of the product matter: the sum wraps, and
    // those bits are identical for signed and unsigned operands.
    assign w_prod      = x_dout * y_dout;
    assign w_acc_sum   = r_valid ? (r_acc + w_prod) : r_acc;

    // Counter successors with wrap after N-1.
    assign w_k_next    = (r_k == c_LAST) ? '0 : r_k + c_CW'(1);
    assign w_j_next    = (r_j == c_LAST) ? '0 : r_j + c_CW'(1);
    assign w_i_next    = (r_i == c_LAST) ? '0 : r_i + c_CW'(1);
    assign w_last_elem = (r_i == c_LAST) && (r_j == c_LAST);

    // Sequencer, accumulator and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_x_addr <= '0;
            r_y_addr <= '0;
            r_z_addr <= '0;
            r_z_we   <= 1'b0;
            r_z_din  <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; accumulate whenever the
            // read issued last cycle has returned.
            r_z_we <= 1'b0;
            r_acc  <= w_acc_sum;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_ACCUM;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_acc    <= '0;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_x_addr <= '0;
                        r_y_addr <= '0;
                    end
                end

                S_ACCUM: begin
                    // The address presented this cycle returns data next cycle.
                    r_valid  <= 1'b1;
                    r_k      <= w_k_next;
                    r_x_addr <= f_addr(r_i, w_k_next);
                    r_y_addr <= f_addr(w_k_next, r_j);
                    if (r_k == c_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Last product lands here; capture the complete sum for WRITE.
                    r_valid  <= 1'b0;
                    r_state  <= S_WRITE;
                    r_z_we   <= 1'b1;
                    r_z_din  <= w_acc_sum;
                    r_z_addr <= f_addr(r_i, r_j);
                end

                S_WRITE: begin
                    r_acc <= '0;
                    r_j   <= w_j_next;
                    if (r_j == c_LAST) begin
                        r_i <= w_i_next;
                    end
                    if (w_last_elem) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_x_addr <= '0;
                        r_y_addr <= '0;
                    end else begin
                        r_state  <= S_ACCUM;
                        r_x_addr <= f_addr((r_j == c_LAST) ? w_i_next : r_i, '0);
                        r_y_addr <= f_addr('0, w_j_next);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign x_rd_addr = r_x_addr;
    assign y_rd_addr = r_y_addr;
    assign z_wr_addr = r_z_addr;
    assign z_wr_en   = r_z_we;
    assign z_din     = r_z_din;

endmodule

`default_nettype wire

// File: tb/tb_matmul_ctrl.sv
//==============================================================================
// Module      : tb_matmul_ctrl
// Description : Scoreboard bench for matmul_ctrl at N=2 and N=8 with BRAM
//               read models of one-cycle latency.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_matmul_ctrl;

    localparam int c_DW = 32;
    localparam int c_AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            st2 = 1'b0;
    logic            st8 = 1'b0;
    logic            done2, busy2, we2, done8, busy8, we8;
    logic [c_AW-1:0] xa2, ya2, za2, xa8, ya8, za8;
    logic [c_DW-1:0] xd2, yd2, zd2, xd8, yd8, zd8;

    logic [c_DW-1:0] x2m [4];
    logic [c_DW-1:0] y2m [4];
    logic [c_DW-1:0] x8m [64];
    logic [c_DW-1:0] y8m [64];

    logic [47:0] sb_q [$];
    int n_cmp = 0;
    int n_err = 0;

    matmul_ctrl #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .MATRIX_DIM(2)) u_dut2 (
        .clock(clk), .reset(rst), .start(st2), .done(done2), .busy(busy2),
        .x_rd_addr(xa2), .x_dout(xd2), .y_rd_addr(ya2), .y_dout(yd2),
        .z_wr_addr(za2), .z_wr_en(we2), .z_din(zd2)
    );

    matmul_ctrl #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .MATRIX_DIM(8)) u_dut8 (
        .clock(clk), .reset(rst), .start(st8), .done(done8), .busy(busy8),
        .x_rd_addr(xa8), .x_dout(xd8), .y_rd_addr(ya8), .y_dout(yd8),
        .z_wr_addr(za8), .z_wr_en(we8), .z_din(zd8)
    );

    // BRAM read ports: data valid one cycle after the address.
    always @(posedge clk) begin
        xd2 <= x2m[xa2[1:0]];
        yd2 <= y2m[ya2[1:0]];
        xd8 <= x8m[xa8[5:0]];
        yd8 <= y8m[ya8[5:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference matrix product, wrapped to 32 bits, pushed in row-major order.
    task automatic push_model(input bit big);
        int n;
        logic [31:0] s, a, b;
        n = big ? 8 : 2;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 32'd0;
                for (int k = 0; k < n; k++) begin
                    a = big ? x8m[i*8+k] : x2m[i*2+k];
                    b = big ? y8m[k*8+j] : y2m[k*2+j];
                    s = s + a * b;
                end
                sb_q.push_back({16'(i*n+j), s});
            end
        end
    endtask

    // Drive start, then watch one DUT cycle by cycle until done (or reset/timeout).
    task automatic run(input bit big, input bit hold, input bit extra, input int rst_at,
                       output int lat, output int wr, output bit busy_ok);
        int          cnt;
        bit          stop;
        logic        dn, bz, we;
        logic [c_AW-1:0] za;
        logic [c_DW-1:0] zd;
        logic [47:0] e;
        lat = -1; wr = 0; busy_ok = 1'b1; cnt = 0; stop = 1'b0;
        if (big) st8 = 1'b1; else st2 = 1'b1;
        while (!stop) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && !hold) begin st2 = 1'b0; st8 = 1'b0; end
            if (extra) begin
                if (cnt == 5 || cnt == 300) st8 = 1'b1;
                else if (cnt == 6 || cnt == 301) st8 = 1'b0;
            end
            dn = big ? done8 : done2;
            bz = big ? busy8 : busy2;
            we = big ? we8 : we2;
            za = big ? za8 : za2;
            zd = big ? zd8 : zd2;
            if (we) begin
                wr++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("z_wr_addr", 64'(za), 64'(e[47:32]));
                    chk("z_din", 64'(zd), 64'(e[31:0]));
                end
            end
            if (dn) begin
                lat  = cnt - 1;
                stop = 1'b1;
            end else if (!bz) begin
                busy_ok = 1'b0;
            end
            if (cnt == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_done", 64'(big ? done8 : done2), 64'd0);
                chk("rst_busy", 64'(big ? busy8 : busy2), 64'd0);
                chk("rst_z_wr_en", 64'(big ? we8 : we2), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    if (big ? we8 : we2) wr++;
                end
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (big ? we8 : we2) wr++;
                end
                sb_q.delete();
                stop = 1'b1;
            end
            if (!stop && cnt >= 2000) begin
                chk("timeout", 64'(cnt), 64'd0);
                stop = 1'b1;
            end
        end
    endtask

    initial begin
        int lat, wr;
        bit bok;
        for (int i = 0; i < 64; i++) begin x8m[i] = '0; y8m[i] = '0; end
        for (int i = 0; i < 4; i++)  begin x2m[i] = '0; y2m[i] = '0; end

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_done8",  64'(done8), 64'd0);
        chk("reset_busy8",  64'(busy8), 64'd0);
        chk("reset_we8",    64'(we8),   64'd0);
        chk("reset_xaddr8", 64'(xa8),   64'd0);
        chk("reset_yaddr8", 64'(ya8),   64'd0);
        chk("reset_zaddr8", 64'(za8),   64'd0);
        chk("reset_zdin8",  64'(zd8),   64'd0);
        chk("reset_done2",  64'(done2), 64'd0);
        chk("reset_busy2",  64'(busy2), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: identity times Y
        x2m = '{32'd1, 32'd0, 32'd0, 32'd1};
        y2m = '{32'd1, 32'd2, 32'd3, 32'd4};
        sb_q.push_back({16'd0, 32'd1});
        sb_q.push_back({16'd1, 32'd2});
        sb_q.push_back({16'd2, 32'd3});
        sb_q.push_back({16'd3, 32'd4});
        run(1'b0, 1'b0, 1'b0, 0, lat, wr, bok);
        chk("t1_latency", 64'(lat), 64'd16);
        chk("t1_writes",  64'(wr),  64'd4);
        chk("t1_busy",    64'(bok), 64'd1);
        chk("t1_sb_left", 64'(sb_q.size()), 64'd0);

        // 2: random N=8
        for (int i = 0; i < 64; i++) begin x8m[i] = $urandom; y8m[i] = $urandom; end
        push_model(1'b1);
        run(1'b1, 1'b0, 1'b0, 0, lat, wr, bok);
        chk("t2_latency", 64'(lat), 64'd640);
        chk("t2_writes",  64'(wr),  64'd64);
        chk("t2_busy",    64'(bok), 64'd1);
        chk("t2_sb_left", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        chk("t2_done_held", 64'(done8), 64'd1);
        chk("t2_busy_low",  64'(busy8), 64'd0);

        // 3: all ones, products wrap to 1
        x2m = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        y2m = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int a = 0; a < 4; a++) sb_q.push_back({16'(a), 32'd2});
        run(1'b0, 1'b0, 1'b0, 0, lat, wr, bok);
        chk("t3_latency", 64'(lat), 64'd16);
        chk("t3_writes",  64'(wr),  64'd4);
        chk("t3_sb_left", 64'(sb_q.size()), 64'd0);

        // 4: start pulses while busy are ignored
        for (int i = 0; i < 64; i++) begin x8m[i] = $urandom; y8m[i] = $urandom; end
        push_model(1'b1);
        run(1'b1, 1'b0, 1'b1, 0, lat, wr, bok);
        chk("t4_latency", 64'(lat), 64'd640);
        chk("t4_writes",  64'(wr),  64'd64);
        chk("t4_busy",    64'(bok), 64'd1);
        chk("t4_sb_left", 64'(sb_q.size()), 64'd0);

        // 5: reset mid-run, then a clean run
        push_model(1'b1);
        run(1'b1, 1'b0, 1'b0, 37, lat, wr, bok);
        chk("t5_writes_before_reset", 64'(wr), 64'd3);
        chk("t5_idle_done", 64'(done8), 64'd0);
        chk("t5_idle_busy", 64'(busy8), 64'd0);
        push_model(1'b1);
        run(1'b1, 1'b0, 1'b0, 0, lat, wr, bok);
        chk("t5_rerun_latency", 64'(lat), 64'd640);
        chk("t5_rerun_writes",  64'(wr),  64'd64);
        chk("t5_rerun_sb_left", 64'(sb_q.size()), 64'd0);

        // 6: start held high, Y changed while in DONE
        x2m = '{32'd2, 32'd3, 32'd5, 32'd7};
        y2m = '{32'd1, 32'd1, 32'd1, 32'd1};
        push_model(1'b0);
        run(1'b0, 1'b1, 1'b0, 0, lat, wr, bok);
        chk("t6_first_latency", 64'(lat), 64'd16);
        chk("t6_first_writes",  64'(wr),  64'd4);
        y2m = '{32'd4, 32'd3, 32'd2, 32'd1};
        push_model(1'b0);
        run(1'b0, 1'b1, 1'b0, 0, lat, wr, bok);
        chk("t6_done_to_done",   64'(lat + 1), 64'd17);
        chk("t6_second_writes",  64'(wr),      64'd4);
        chk("t6_sb_left",        64'(sb_q.size()), 64'd0);
        st2 = 1'b0;
        @(negedge clk);
        chk("t6_done_held", 64'(done2), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
